xbus_arbiter: RTL
=================

XBUS_ARBITER -- requirements
Module: xbus_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum xbus wait cycles per access; 0 disables the timeout.
REQ-002 Ports (N in {0,1}; port 0 = instruction fetch, port 1 = load/store):
- clk  in  1  — the single clock; all state on its rising edge.
- rst  in  1  — reset, synchronous, active-high.
- mN_req  in  1  — access request; the requester holds it and all mN_* request fields stable until mN_gnt.
- mN_we  in  1  — 1 = write, 0 = read.
- mN_be  in  4  — byte enables, already lane-aligned.
- mN_addr  in  32  — byte address.
- mN_wdata  in  32  — write data, already lane-aligned.
- mN_gnt  out  1  — one-cycle pulse: request accepted and captured at this edge.
- mN_rvalid  out  1  — one-cycle completion pulse (reads and writes).
- mN_rdata  out  32  — read data, valid with mN_rvalid.
- mN_err  out  1  — timeout error, valid with mN_rvalid.
- xbus_valid  out  1  — access in progress on xbus.
- xbus_we  out  1  — write strobe.
- xbus_be  out  4  — byte enables.
- xbus_addr  out  32  — address.
- xbus_wdata  out  32  — write data.
- xbus_ready  in  1  — slave completes the access this cycle.
- xbus_rdata  in  32  — read data, valid with xbus_ready.

Function
REQ-003 The block SHALL implement two states, IDLE and ACCESS.
REQ-004 In IDLE with at least one mN_req, the block SHALL assert mN_gnt combinationally for exactly one port, capture that port's we/be/addr/wdata, and enter ACCESS at the next edge.
REQ-005 Arbitration SHALL be round-robin:
- with both requesting, grant the port not granted last;
- with one requesting, grant it;
- the last-grant pointer updates only on a grant.
REQ-006 In ACCESS, xbus_valid SHALL be 1 and xbus_we/be/addr/wdata SHALL equal the captured fields, unchanged until the access ends.
REQ-007 When xbus_ready=1 in ACCESS, the block SHALL register the completion and return to IDLE. In the following cycle the granted port sees:
- mN_rvalid=1;
- mN_err=0;
- mN_rdata = xbus_rdata for reads, 0 for writes.
REQ-008 Latency SHALL be: gnt at cycle T, xbus_valid from T+1, ready at cycle R >= T+1, rvalid at R+1; with immediate ready, one access completes every 2 cycles per grant.
REQ-009 A new grant SHALL be permitted in the same cycle that mN_rvalid is asserted (the state is IDLE then).
REQ-010 A 16-bit wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle without xbus_ready.
- If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES, the block SHALL abort: xbus_valid=0 next cycle, and the granted port gets mN_rvalid=1, mN_err=1, mN_rdata=0.
- xbus_ready arriving in the same cycle as the timeout SHALL take precedence: normal completion, err=0.
REQ-011 xbus_ready SHALL be ignored in IDLE.
REQ-012 The mN_rvalid/mN_err/mN_rdata outputs SHALL be registered and SHALL be 0 for the non-granted port.
REQ-013 mN_gnt SHALL never be asserted in ACCESS, and never to both ports in the same cycle.
REQ-014 be=0 SHALL be forwarded unchanged; the arbiter performs no alignment or extension.

Reset
REQ-015 On rst=1 at an edge, the block SHALL:
- enter IDLE;
- clear the wait counter;
- set the pointer so port 1 wins the first contention.
REQ-016 During reset all outputs SHALL be 0: xbus_valid, xbus_we, xbus_be, xbus_addr, xbus_wdata, mN_gnt, mN_rvalid, mN_rdata, mN_err.
REQ-017 Reset mid-access SHALL drop xbus_valid at the next edge and generate no mN_rvalid for the aborted access.

Verification
REQ-018 Single read: m0 reads addr 0x100, slave returns ready one cycle after valid with rdata 0x12345678 -> m0_gnt at T, xbus_valid at T+1..T+2, m0_rvalid=1 with 0x12345678 at T+3.
REQ-019 Contention after reset: m0 and m1 request together -> m1 granted first, m0 granted in the rvalid cycle of m1; m1 again wins the next tie only after m0 has been served.
REQ-020 Write: m1 writes be=4'b0100, wdata=0x00AB0000 -> xbus fields match exactly, m1_rvalid=1, m1_rdata=0, m1_err=0.
REQ-021 Timeout: TIMEOUT_CYCLES=4 and xbus_ready held low -> xbus_valid lasts 4 cycles, then rvalid=1, err=1, rdata=0; ready asserted on the 4th cycle -> err=0 with normal data.
REQ-022 Reset mid-access: rst during ACCESS -> xbus_valid=0 next cycle, no rvalid, all outputs 0.

Source files
------------

// File: rtl/xbus_arbiter.sv
// Two-port round-robin arbiter onto a single xbus master port.
// Port 0 is instruction fetch, port 1 is load/store.
module xbus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        xbus_valid,
    output logic        xbus_we,
    output logic [3:0]  xbus_be,
    output logic [31:0] xbus_addr,
    output logic [31:0] xbus_wdata,
    input  logic        xbus_ready,
    input  logic [31:0] xbus_rdata
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic        own_q, own_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] cnt_q, cnt_d;
    logic        rv0_q, rv0_d, rv1_q, rv1_d;
    logic        err0_q, err0_d, err1_q, err1_d;
    logic [31:0] rd0_q, rd0_d, rd1_q, rd1_d;

    logic        gnt0, gnt1;
    logic        done, abort;
    logic        tmo_hit;
    logic [31:0] cnt_next;

    // Timeout fires on the wait cycle whose increment would reach the limit.
    assign cnt_next = 32'(cnt_q) + 32'd1;
    assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (cnt_next == TIMEOUT_CYCLES);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        own_d   = own_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (m0_req && (!m1_req || last_q)) begin
                    gnt0 = 1'b1;
                end else if (m1_req) begin
                    gnt1 = 1'b1;
                end
                if (gnt0 || gnt1) begin
                    state_d = ACCESS;
                    last_d  = gnt1;
                    own_d   = gnt1;
                    cnt_d   = 16'd0;
                    we_d    = gnt1 ? m1_we    : m0_we;
                    be_d    = gnt1 ? m1_be    : m0_be;
                    addr_d  = gnt1 ? m1_addr  : m0_addr;
                    wdata_d = gnt1 ? m1_wdata : m0_wdata;
                end
            end
            ACCESS: begin
                if (xbus_ready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        endcase
    end

    always_comb begin
        rv0_d  = 1'b0;
        rv1_d  = 1'b0;
        err0_d = 1'b0;
        err1_d = 1'b0;
        rd0_d  = 32'd0;
        rd1_d  = 32'd0;
        if (done || abort) begin
            if (own_q) begin
                rv1_d  = 1'b1;
                err1_d = abort;
                rd1_d  = (done && !we_q) ? xbus_rdata : 32'd0;
            end else begin
                rv0_d  = 1'b1;
                err0_d = abort;
                rd0_d  = (done && !we_q) ? xbus_rdata : 32'd0;
            end
        end
    end

    // Reset clears last_q so port 1 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
            own_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            cnt_q   <= 16'd0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            rd0_q   <= 32'd0;
            rd1_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            own_q   <= own_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    // Outputs are forced low while rst is high, even before the reset edge.
    assign xbus_valid = (state_q == ACCESS) && !rst;
    assign xbus_we    = xbus_valid & we_q;
    assign xbus_be    = xbus_valid ? be_q    : 4'd0;
    assign xbus_addr  = xbus_valid ? addr_q  : 32'd0;
    assign xbus_wdata = xbus_valid ? wdata_q : 32'd0;

    assign m0_gnt    = gnt0 & !rst;
    assign m1_gnt    = gnt1 & !rst;
    assign m0_rvalid = rv0_q & !rst;
    assign m1_rvalid = rv1_q & !rst;
    assign m0_err    = err0_q & !rst;
    assign m1_err    = err1_q & !rst;
    assign m0_rdata  = rst ? 32'd0 : rd0_q;
    assign m1_rdata  = rst ? 32'd0 : rd1_q;

endmodule
